// File: rtl/srt4_div.sv
// srt4_div: sequential unsigned divider, radix-4 SRT with digits {-2..+2}.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active HIGH (block is in reset while rst_n=1)
//   start      request, sampled only in IDLE
//   dividend   unsigned dividend, captured when start is accepted
//   divisor    unsigned divisor, captured when start is accepted
//   quotient   registered quotient
//   reminder   registered remainder
//   divfinish  one-cycle pulse, results valid
//   diverror   divide-by-zero flag, valid with divfinish, held until next result
//
// Handshake: start is accepted on a rising edge where the FSM is in IDLE; the
// result appears with divfinish=1 for exactly one cycle (state DONE) and stays
// on quotient/reminder/diverror until the next result load. start is ignored
// outside IDLE, so holding it high runs operations back to back.
//
// Datapath: the divisor is left-justified by s = lzc(divisor) and the dividend
// is shifted by the same s. The partial remainder w_reg is an integer; the low
// dividend bits not yet consumed sit left-aligned in l_reg and enter w two
// bits per step (long-division style), so w_reg stays DW+4 bits wide.

// On-the-fly quotient conversion: q_reg tracks Q, qm_reg tracks Q-1.
// Arithmetic is modulo 2^W; the final quotient always fits in W bits.
module srt4_otf #(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              en,
    input  logic signed [2:0] digit,
    output logic [W-1:0]      q,
    output logic [W-1:0]      qm
);
    logic [W-1:0] q_reg, qm_reg;
    logic [W-1:0] q_nx, qm_nx;

    always_comb begin
        q_nx  = q_reg;
        qm_nx = qm_reg;
        case (digit)
            3'b010: begin q_nx = {q_reg[W-3:0], 2'd2};  qm_nx = {q_reg[W-3:0], 2'd1};  end
            3'b001: begin q_nx = {q_reg[W-3:0], 2'd1};  qm_nx = {q_reg[W-3:0], 2'd0};  end
            3'b000: begin q_nx = {q_reg[W-3:0], 2'd0};  qm_nx = {qm_reg[W-3:0], 2'd3}; end
            3'b111: begin q_nx = {qm_reg[W-3:0], 2'd3}; qm_nx = {qm_reg[W-3:0], 2'd2}; end
            3'b110: begin q_nx = {qm_reg[W-3:0], 2'd2}; qm_nx = {qm_reg[W-3:0], 2'd1}; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg  <= '0;
            qm_reg <= '0;
        end else if (init) begin
            q_reg  <= '0;
            qm_reg <= '1;  // Q-1 with Q=0, modulo 2^W
        end else if (en) begin
            q_reg  <= q_nx;
            qm_reg <= qm_nx;
        end
    end

    assign q  = q_reg;
    assign qm = qm_reg;
endmodule

module srt4_div #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] reminder,
    output logic          divfinish,
    output logic          diverror
);
    localparam int WW = DW + 4;
    localparam int QW = DW + 2;
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(DW / 2 + 2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NORM = 3'd1,
        ITER = 3'd2,
        CORR = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [DW-1:0]        dvd_reg, dvs_reg, d_reg;
    logic signed [WW-1:0] w_reg;
    logic [QW-1:0]        l_reg;
    logic [SW-1:0]        shamt_reg;
    logic [CW-1:0]        iterations_reg, counter;
    logic [DW-1:0]        otf_q, otf_qm;

    function automatic logic [SW-1:0] lzc(input logic [DW-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < DW; i++)
            if (v[i]) n = SW'(DW - 1 - i);
        return n;
    endfunction

    // Normalization. Steps n = floor((s+1)/2)+1 make 4^n >= 3*2^s, which keeps
    // the initial remainder below d/2 and inside the |w| <= 2d/3 bound.
    logic [SW-1:0]   norm_s;
    logic [CW-1:0]   norm_n;
    logic [DW-1:0]   norm_d, norm_r0;
    logic [2*DW-1:0] norm_x;
    logic [QW-1:0]   norm_l;

    always_comb begin
        norm_s  = lzc(dvs_reg);
        norm_n  = CW'((int'(norm_s) + 1) / 2 + 1);
        norm_d  = dvs_reg << norm_s;
        norm_x  = {{DW{1'b0}}, dvd_reg} << norm_s;
        norm_r0 = DW'(norm_x >> (2 * int'(norm_n)));
        norm_l  = QW'(norm_x << (QW - 2 * int'(norm_n)));
    end

    // One SRT step. p_hat is 4w truncated to 1/16 of the normalized scale;
    // thresholds indexed by the three divisor bits below the leading one.
    logic signed [WW-1:0] p_w, d_ext, w_next;
    logic signed [7:0]    p_hat, m2, m1;
    logic signed [2:0]    q_dig;

    always_comb begin
        d_ext = $signed({4'b0000, d_reg});
        p_w   = (w_reg <<< 2) + $signed({{(WW-2){1'b0}}, l_reg[QW-1 -: 2]});
        p_hat = p_w[WW-1 -: 8];
        case (d_reg[DW-2 -: 3])
            3'd0:    begin m2 = 8'sd12; m1 = 8'sd4; end
            3'd1:    begin m2 = 8'sd14; m1 = 8'sd4; end
            3'd2:    begin m2 = 8'sd15; m1 = 8'sd4; end
            3'd3:    begin m2 = 8'sd16; m1 = 8'sd4; end
            3'd4:    begin m2 = 8'sd18; m1 = 8'sd6; end
            3'd5:    begin m2 = 8'sd20; m1 = 8'sd6; end
            3'd6:    begin m2 = 8'sd22; m1 = 8'sd8; end
            default: begin m2 = 8'sd24; m1 = 8'sd8; end
        endcase
        if (p_hat >= m2)       q_dig = 3'sd2;
        else if (p_hat >= m1)  q_dig = 3'sd1;
        else if (p_hat >= -m1) q_dig = 3'sd0;
        else if (p_hat >= -m2) q_dig = -3'sd1;
        else                   q_dig = -3'sd2;
        case (q_dig)
            3'sd2:   w_next = p_w - (d_ext <<< 1);
            3'sd1:   w_next = p_w - d_ext;
            -3'sd1:  w_next = p_w + d_ext;
            -3'sd2:  w_next = p_w + (d_ext <<< 1);
            default: w_next = p_w;
        endcase
    end

    // A negative final remainder lies in [-2d/3, 0); adding d lands in [0, d),
    // so DW-bit modular addition is exact.
    logic [DW-1:0] rem_fix;
    assign rem_fix = w_reg[DW-1:0] + (w_reg[WW-1] ? d_reg : '0);

    srt4_otf #(.W(DW)) u3 (
        .clk   (clk),
        .rst   (rst_n),
        .init  (state == NORM),
        .en    (state == ITER),
        .digit (q_dig),
        .q     (otf_q),
        .qm    (otf_qm)
    );

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = NORM;
            NORM: state_nx = ((dvs_reg == '0) || (dvd_reg < dvs_reg)) ? DONE : ITER;
            ITER: if (counter == iterations_reg - CW'(1)) state_nx = CORR;
            CORR: state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            dvd_reg        <= '0;
            dvs_reg        <= '0;
            d_reg          <= '0;
            w_reg          <= '0;
            l_reg          <= '0;
            shamt_reg      <= '0;
            iterations_reg <= '0;
            counter        <= '0;
            quotient       <= '0;
            reminder       <= '0;
            divfinish      <= 1'b0;
            diverror       <= 1'b0;
        end else begin
            divfinish <= (state_nx == DONE);
            case (state)
                IDLE: if (start) begin
                    dvd_reg <= dividend;
                    dvs_reg <= divisor;
                end
                NORM: begin
                    counter        <= '0;
                    d_reg          <= norm_d;
                    w_reg          <= $signed({4'b0000, norm_r0});
                    l_reg          <= norm_l;
                    shamt_reg      <= norm_s;
                    iterations_reg <= norm_n;
                    if (dvs_reg == '0) begin
                        quotient <= '1;
                        reminder <= dvd_reg;
                        diverror <= 1'b1;
                    end else if (dvd_reg < dvs_reg) begin
                        quotient <= '0;
                        reminder <= dvd_reg;
                        diverror <= 1'b0;
                    end
                end
                ITER: begin
                    w_reg   <= w_next;
                    l_reg   <= l_reg << 2;
                    counter <= counter + CW'(1);
                end
                CORR: begin
                    // qm already holds Q-1 for the negative-remainder case
                    quotient <= w_reg[WW-1] ? otf_qm : otf_q;
                    reminder <= rem_fix >> shamt_reg;
                    diverror <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_srt4_div.sv
module tb_srt4_div;
    localparam int DW = 32;
    localparam int EW = 2 * DW + 1;
    localparam int LAT_MAX = DW / 2 + 5;
    localparam int WAIT_MAX = 40;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend, divisor;
    logic [DW-1:0] quotient, reminder;
    logic          divfinish, diverror;

    int total = 0;
    int bad = 0;
    logic [EW-1:0] exp_q[$];
    logic prev_fin = 1'b0;

    srt4_div #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .reminder  (reminder),
        .divfinish (divfinish),
        .diverror  (diverror)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain integer division
    function automatic logic [EW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (b == '0) return {1'b1, {DW{1'b1}}, a};
        return {1'b0, a / b, a % b};
    endfunction

    task automatic check_val(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_quotient"}, quotient, '0);
        check_val({tag, "_reminder"}, reminder, '0);
        check_val({tag, "_divfinish"}, DW'(divfinish), '0);
        check_val({tag, "_diverror"}, DW'(diverror), '0);
    endtask

    // monitor: pops one expectation per divfinish pulse
    always @(negedge clk) begin
        if (rst_n) begin
            prev_fin = 1'b0;
        end else begin
            if (divfinish) begin
                total++;
                if (prev_fin) begin
                    bad++;
                    $display("FAIL pulse_width: divfinish high two cycles in a row");
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_finish: q=%h r=%h err=%b with nothing pending",
                             quotient, reminder, diverror);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    if ({diverror, quotient, reminder} !== e) begin
                        bad++;
                        $display("FAIL result: got err=%b q=%h r=%h expected err=%b q=%h r=%h",
                                 diverror, quotient, reminder, e[EW-1], e[2*DW-1:DW], e[DW-1:0]);
                    end
                end
            end
            prev_fin = divfinish;
        end
    end

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b0;
    endtask

    // single directed operation with latency check (acceptance edge to finish)
    task automatic run_one(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int lat;
        logic special;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end while (!divfinish && lat < WAIT_MAX);
        special = (b == '0) || (a < b);
        total++;
        if (special ? (lat != 2) : (lat < 3 || lat > LAT_MAX)) begin
            bad++;
            $display("FAIL latency %h/%h: got %0d cycles, required %s", a, b, lat,
                     special ? "2" : "3..DW/2+5");
        end
    endtask

    task automatic wait_fin(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < WAIT_MAX && !ok) begin
            @(negedge clk);
            n++;
            if (divfinish) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL timeout: no divfinish within %0d cycles", WAIT_MAX);
        end
    endtask

    task automatic rand_ops(output logic [DW-1:0] a, output logic [DW-1:0] b);
        a = $urandom() >> $urandom_range(0, 31);
        b = $urandom() >> $urandom_range(0, 31);
        if ($urandom_range(0, 49) == 0) b = '0;
    endtask

    // back-to-back with start held high; new operands go in during DONE
    task automatic run_random(input int n);
        logic [DW-1:0] a, b;
        bit ok;
        @(negedge clk);
        rand_ops(a, b);
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        start = 1'b1;
        for (int i = 1; i < n; i++) begin
            wait_fin(ok);
            if (!ok) break;
            rand_ops(a, b);
            dividend = a;
            divisor  = b;
            exp_q.push_back(model(a, b));
        end
        wait_fin(ok);
        start = 1'b0;
    endtask

    // main sequence
    initial begin
        int seen;
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        do_reset();

        run_one(32'd100, 32'd7);
        run_one(32'hFFFF_FFFF, 32'h0000_0001);
        run_one(32'd5, 32'd0);
        run_one(32'd9, 32'd3);
        run_one(32'd3, 32'd10);
        run_one(32'h8000_0000, 32'h8000_0000);
        run_one(32'h7FFF_FFFF, 32'h0001_0000);

        // abort a long division while iterating
        @(negedge clk);
        dividend = 32'hFFFF_FFFF;
        divisor  = 32'h0000_0001;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (divfinish) seen++;
        end
        check_val("abort_no_finish", DW'(seen), '0);

        run_one(32'd100, 32'd7);
        run_one(32'hDEAD_BEEF, 32'h0000_1234);

        run_random(1000);

        repeat (5) @(negedge clk);
        check_val("pending_empty", DW'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
